// File: rtl/multicycle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multicycle_sequencer
//  Purpose  : Control FSM that steps an RV32I datapath through
//             FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK and drives
//             its load/write/request strobes. Select signals stay with the
//             datapath's own decode logic; this block only gates enables.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT    cycles to wait for a memory ready before trapping (0 = never)
//    CNT_WIDTH  width of the retired-instruction counter
//  Ports
//    clk_i          system clock, rising edge
//    rst_ni         asynchronous active-low reset
//    start_i        run enable, sampled only in IDLE and WRITEBACK
//    opcode_i       instruction[6:2] from the instruction register
//    funct3_i       instruction[14:12]
//    imem_ready_i   instruction word valid this cycle
//    dmem_ready_i   data access completes this cycle
//    imem_req_o     instruction fetch request
//    ir_en_o        instruction register load strobe (Mealy on imem_ready_i)
//    pc_en_o        PC load strobe
//    reg_WE_L_o     register file write enable, active-low
//    dmem_req_o     data memory request
//    dmem_we_o      data memory write, qualified by dmem_req_o
//    halted_o       sticky, ECALL/EBREAK reached
//    trap_o         sticky, fault taken
//    trap_cause_o   01 illegal opcode, 10 imem timeout, 11 dmem timeout
//    state_o        current state, for debug
//    retired_o      completed-instruction count, wraps
// ============================================================================
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [4:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic                 imem_ready_i,
    input  logic                 dmem_ready_i,
    output logic                 imem_req_o,
    output logic                 ir_en_o,
    output logic                 pc_en_o,
    output logic                 reg_WE_L_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic                 halted_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] retired_o
);

    // Wait counter only needs to reach TIMEOUT; keep at least one bit when
    // the timeout is disabled.
    localparam int unsigned     WAIT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);
    localparam bit              TIMEOUT_EN  = (TIMEOUT != 0);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_TRAP      = 3'd7
    } state_e;

    // Opcode class captured in DECODE so later states do not depend on the
    // instruction register staying stable.
    typedef enum logic [1:0] {
        CLS_REG   = 2'd0,   // ALU / jumps / upper-immediate: write rd
        CLS_NOREG = 2'd1,   // BRANCH, MISC-MEM: no rd write
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } cls_e;

    state_e              state_q,   state_d;
    cls_e                cls_q,     cls_d;
    logic [1:0]          cause_q,   cause_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    cls_e dec_cls;
    logic dec_legal;
    logic dec_halt;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_cls   = CLS_REG;
        dec_legal = 1'b1;
        dec_halt  = 1'b0;
        unique case (opcode_i)
            5'b00000: dec_cls = CLS_LOAD;    // LOAD
            5'b00011: dec_cls = CLS_NOREG;   // MISC-MEM (FENCE as nop)
            5'b00100: dec_cls = CLS_REG;     // OP-IMM
            5'b00101: dec_cls = CLS_REG;     // AUIPC
            5'b01000: dec_cls = CLS_STORE;   // STORE
            5'b01100: dec_cls = CLS_REG;     // OP
            5'b01101: dec_cls = CLS_REG;     // LUI
            5'b11000: dec_cls = CLS_NOREG;   // BRANCH
            5'b11001: dec_cls = CLS_REG;     // JALR
            5'b11011: dec_cls = CLS_REG;     // JAL
            5'b11100: begin                  // SYSTEM: only ECALL/EBREAK
                dec_halt  = (funct3_i == 3'b000);
                dec_legal = (funct3_i == 3'b000);
            end
            default:  dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_REG;
            cause_q   <= 2'b00;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cause_d    = cause_q;
        wait_d     = '0;            // cleared on every transition
        retired_d  = retired_q;
        imem_req_o = 1'b0;
        ir_en_o    = 1'b0;
        pc_en_o    = 1'b0;
        reg_WE_L_o = 1'b1;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_en_o    = imem_ready_i;
                if (imem_ready_i) begin
                    state_d = S_DECODE;
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_CNT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (!dec_legal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) state_d = S_MEMORY;
                else                                               state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (cls_q == CLS_STORE);
                if (dmem_ready_i) begin
                    state_d = S_WRITEBACK;
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_CNT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_en_o    = 1'b1;
                reg_WE_L_o = (cls_q == CLS_STORE) || (cls_q == CLS_NOREG);
                retired_d  = retired_q + 1'b1;
                state_d    = start_i ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;   // leave only through reset
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign halted_o     = (state_q == S_HALT);
    assign trap_o       = (state_q == S_TRAP);
    assign trap_cause_o = cause_q;
    assign state_o      = state_q;
    assign retired_o    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_sequencer
//  Purpose  : Self-checking bench for multicycle_sequencer. Each instruction
//             is expanded into its expected cycle-by-cycle phase trace from
//             the sequencing rules (wait counts, opcode class, start level)
//             and every cycle's full output vector is compared.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int unsigned TIMEOUT   = 4;
    localparam int unsigned CNT_WIDTH = 4;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                           ST_HALT = 3'd6, ST_TRAP = 3'd7;

    localparam logic [4:0] OP_LOAD = 5'b00000, OP_MISC = 5'b00011, OP_IMM = 5'b00100,
                           OP_AUIPC = 5'b00101, OP_STORE = 5'b01000, OP_OP = 5'b01100,
                           OP_LUI = 5'b01101, OP_BRANCH = 5'b11000, OP_JALR = 5'b11001,
                           OP_JAL = 5'b11011, OP_SYSTEM = 5'b11100;

    // instruction kinds used by the reference model
    localparam int K_ILL = 0, K_HALT = 1, K_REG = 2, K_NOREG = 3, K_LOAD = 4, K_STORE = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [4:0]           opcode = 5'd0;
    logic [2:0]           funct3 = 3'd0;
    logic                 imem_ready = 1'b0;
    logic                 dmem_ready = 1'b0;
    logic                 imem_req, ir_en, pc_en, reg_we_l, dmem_req, dmem_we, halted, trap;
    logic [1:0]           trap_cause;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] retired;

    int          total = 0;
    int          bad   = 0;
    int unsigned m_retired = 0;
    logic [1:0]  m_cause   = 2'b00;
    int          fate;

    logic [4:0] legal_ops [10];

    multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .imem_ready_i (imem_ready),
        .dmem_ready_i (dmem_ready),
        .imem_req_o   (imem_req),
        .ir_en_o      (ir_en),
        .pc_en_o      (pc_en),
        .reg_WE_L_o   (reg_we_l),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .halted_o     (halted),
        .trap_o       (trap),
        .trap_cause_o (trap_cause),
        .state_o      (state),
        .retired_o    (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // observed vector: state, imem_req, ir_en, pc_en, reg_we_l, dmem_req,
    // dmem_we, halted, trap, trap_cause, retired
    wire logic [16:0] obs = {state, imem_req, ir_en, pc_en, reg_we_l, dmem_req,
                             dmem_we, halted, trap, trap_cause, retired};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [16:0] ev(input logic [2:0] st, input logic imreq, input logic ir,
                                       input logic pc, input logic wel, input logic dreq,
                                       input logic dwe);
        logic [3:0] r;
        r = 4'(m_retired % (32'd1 << CNT_WIDTH));
        return {st, imreq, ir, pc, wel, dreq, dwe, st == ST_HALT, st == ST_TRAP, m_cause, r};
    endfunction

    function automatic int classify(input logic [4:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD:                                            return K_LOAD;
            OP_STORE:                                           return K_STORE;
            OP_MISC, OP_BRANCH:                                 return K_NOREG;
            OP_IMM, OP_AUIPC, OP_OP, OP_LUI, OP_JALR, OP_JAL:   return K_REG;
            OP_SYSTEM:                                          return (f3 == 3'b000) ? K_HALT : K_ILL;
            default:                                            return K_ILL;
        endcase
    endfunction

    // Drive one cycle's inputs at the falling edge, compare, advance.
    task automatic cyc(input string tag, input logic st, input logic ir, input logic dr,
                       input logic [16:0] exp);
        start      = st;
        imem_ready = ir;
        dmem_ready = dr;
        #1;
        check(tag, 32'(obs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        m_retired = 0;
        m_cause   = 2'b00;
        #1;
        check("reset_async", 32'(obs), 32'(ev(ST_IDLE, 0, 0, 0, 1, 0, 0)));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // n-1 idle cycles with start low, then one with start high
    task automatic idle(input int n);
        for (int i = 1; i < n; i++) cyc("idle", 1'b0, rbit(), rbit(), ev(ST_IDLE, 0, 0, 0, 1, 0, 0));
        cyc("idle_go", 1'b1, rbit(), rbit(), ev(ST_IDLE, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic hold(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 5'($urandom);
            funct3 = 3'($urandom);
            cyc((st == ST_HALT) ? "halt_hold" : "trap_hold", rbit(), rbit(), rbit(),
                ev(st, 0, 0, 0, 1, 0, 0));
        end
    endtask

    // One instruction from FETCH entry. wf/wm: ready-low cycles before the
    // fetch/data access completes. fate: 0 retired, 1 halted, 2 trapped.
    task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input int wf,
                             input int wm, input logic st_wb, output int fate_o);
        int  kind;
        logic writes;
        kind   = classify(op, f3);
        writes = (kind == K_REG) || (kind == K_LOAD);
        opcode = op;
        funct3 = f3;
        for (int k = 0; k <= int'(TIMEOUT); k++) begin
            if (k == wf) begin
                cyc("fetch_done", rbit(), 1'b1, rbit(), ev(ST_FETCH, 1, 1, 0, 1, 0, 0));
                break;
            end
            cyc("fetch_wait", rbit(), 1'b0, rbit(), ev(ST_FETCH, 1, 0, 0, 1, 0, 0));
            if (k == int'(TIMEOUT)) begin
                m_cause = 2'b10;
                fate_o  = 2;
                return;
            end
        end
        cyc("decode", rbit(), rbit(), rbit(), ev(ST_DECODE, 0, 0, 0, 1, 0, 0));
        if (kind == K_ILL) begin
            m_cause = 2'b01;
            fate_o  = 2;
            return;
        end
        if (kind == K_HALT) begin
            fate_o = 1;
            return;
        end
        // class must already be captured; scramble the instruction bits
        opcode = 5'($urandom);
        funct3 = 3'($urandom);
        cyc("execute", rbit(), rbit(), rbit(), ev(ST_EXEC, 0, 0, 0, 1, 0, 0));
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int k = 0; k <= int'(TIMEOUT); k++) begin
                if (k == wm) begin
                    cyc("mem_done", rbit(), rbit(), 1'b1,
                        ev(ST_MEM, 0, 0, 0, 1, 1, kind == K_STORE));
                    break;
                end
                cyc("mem_wait", rbit(), rbit(), 1'b0,
                    ev(ST_MEM, 0, 0, 0, 1, 1, kind == K_STORE));
                if (k == int'(TIMEOUT)) begin
                    m_cause = 2'b11;
                    fate_o  = 2;
                    return;
                end
            end
        end
        cyc("writeback", st_wb, rbit(), rbit(), ev(ST_WB, 0, 0, 1, !writes, 0, 0));
        m_retired++;
        fate_o = 0;
    endtask

    initial begin
        legal_ops = '{OP_LOAD, OP_MISC, OP_IMM, OP_AUIPC, OP_STORE,
                      OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};

        // ---------------- directed ----------------
        do_reset();
        idle(1);
        run_instr(OP_OP, 3'd0, 0, 0, 1'b0, fate);        // 4-cycle ALU, start dropped
        idle(2);                                          // retired now 1
        run_instr(OP_LOAD, 3'd2, 0, 3, 1'b1, fate);       // 8 cycles total
        run_instr(OP_STORE, 3'd2, 0, 0, 1'b1, fate);
        run_instr(OP_BRANCH, 3'd0, 1, 0, 1'b1, fate);
        run_instr(OP_MISC, 3'd0, 0, 0, 1'b1, fate);
        run_instr(OP_OP, 3'd0, 4, 0, 1'b1, fate);         // ready exactly at limit
        run_instr(OP_LOAD, 3'd0, 0, 4, 1'b0, fate);
        idle(3);

        run_instr(5'b11111, 3'd0, 0, 0, 1'b1, fate);      // illegal
        hold(ST_TRAP, 20);

        do_reset(); idle(1);
        run_instr(OP_SYSTEM, 3'd0, 0, 0, 1'b1, fate);     // ECALL/EBREAK
        hold(ST_HALT, 20);

        do_reset(); idle(1);
        run_instr(OP_SYSTEM, 3'd1, 0, 0, 1'b1, fate);     // CSR-type: illegal
        hold(ST_TRAP, 3);

        do_reset(); idle(1);
        run_instr(OP_OP, 3'd0, 99, 0, 1'b1, fate);        // imem timeout
        hold(ST_TRAP, 5);

        do_reset(); idle(1);
        run_instr(OP_STORE, 3'd0, 0, 99, 1'b1, fate);     // dmem timeout
        hold(ST_TRAP, 5);

        // retired counter wrap
        do_reset(); idle(1);
        for (int i = 0; i < 16; i++)
            run_instr(legal_ops[i % 10], 3'd0, 0, 0, (i != 15), fate);
        #1;
        check("retired_wrap", 32'(retired), m_retired % (32'd1 << CNT_WIDTH));
        @(negedge clk);
        idle(1);

        // reset while in MEMORY
        run_instr(OP_OP, 3'd0, 0, 0, 1'b1, fate);
        opcode = OP_LOAD;
        cyc("abort_fetch", 1'b1, 1'b1, 1'b0, ev(ST_FETCH, 1, 1, 0, 1, 0, 0));
        cyc("abort_decode", 1'b1, 1'b0, 1'b0, ev(ST_DECODE, 0, 0, 0, 1, 0, 0));
        cyc("abort_exec", 1'b1, 1'b0, 1'b0, ev(ST_EXEC, 0, 0, 0, 1, 0, 0));
        dmem_ready = 1'b0;
        #1;
        check("abort_mem", 32'(obs), 32'(ev(ST_MEM, 0, 0, 0, 1, 1, 0)));
        #2;
        rst_n = 1'b0;
        m_retired = 0;
        m_cause   = 2'b00;
        #1;
        check("abort_reset", 32'(obs), 32'(ev(ST_IDLE, 0, 0, 0, 1, 0, 0)));
        dmem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("abort_reset_hold", 32'(obs), 32'(ev(ST_IDLE, 0, 0, 0, 1, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        run_instr(OP_LOAD, 3'd0, 0, 0, 1'b0, fate);
        idle(1);

        // ---------------- randomized ----------------
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            idle($urandom_range(1, 3));
            for (int i = 0; i < 30; i++) begin
                int       r;
                logic [4:0] op;
                logic [2:0] f3;
                int       wf, wm;
                logic     st_wb;
                r  = $urandom_range(0, 99);
                f3 = 3'($urandom);
                if (r < 84)      op = legal_ops[$urandom_range(0, 9)];
                else if (r < 90) begin op = OP_SYSTEM; if (rbit()) f3 = 3'd0; end
                else             op = 5'($urandom);
                wf = ($urandom_range(0, 99) < 88) ? $urandom_range(0, 3) : $urandom_range(4, 6);
                wm = ($urandom_range(0, 99) < 88) ? $urandom_range(0, 3) : $urandom_range(4, 6);
                st_wb = ($urandom_range(0, 3) != 0);
                run_instr(op, f3, wf, wm, st_wb, fate);
                if (fate == 1) begin hold(ST_HALT, 4); break; end
                if (fate == 2) begin hold(ST_TRAP, 4); break; end
                if (!st_wb) idle($urandom_range(1, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
